if_stage: RTL and testbench

Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the decode stage. It generates the fetch PC and drives the synchronous instruction SRAM. It holds the fetched instruction through decode back-pressure, and presents PC/NPC/NNPC plus the instruction to decode using the valid/allowin handshake. Taken branches resolved in decode redirect fetch after the delay slot.

---
 rtl/if_stage.sv | 103 ++++++++++
 tb/tb_if_stage.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage
//
// Instruction-fetch stage of the 5-stage MIPS pipeline. It generates the
// fetch PC, drives the synchronous instruction SRAM and holds the fetched
// instruction for decode through back-pressure. The instruction is handed to
// decode with the valid/allowin handshake. Taken branches resolved in decode
// redirect fetch once the delay slot has moved into decode.
//
// Ports:
//   clk              system clock, rising edge
//   rst              synchronous reset, active-high
//   id_allowin_in    decode can accept an instruction this cycle
//   id_brcal_res_in  instruction in decode is a taken branch/jump
//   id_bjpc_res_in   branch/jump target
//   if_valid_out     IF holds a valid instruction
//   if_PC_out        PC of the held instruction
//   if_NPC_out       PC + 4
//   if_NNPC_out      PC + 8
//   if_Instruct_out  held instruction word (zero on a fetch address error)
//   if_adel_out      held PC is misaligned
//   inst_sram_en     SRAM read strobe, data returns the following cycle
//   inst_sram_addr   SRAM read address
//   inst_sram_rdata  SRAM read data
// ---------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_allowin_in,
  input  logic        id_brcal_res_in,
  input  logic [31:0] id_bjpc_res_in,
  output logic        if_valid_out,
  output logic [31:0] if_PC_out,
  output logic [31:0] if_NPC_out,
  output logic [31:0] if_NNPC_out,
  output logic [31:0] if_Instruct_out,
  output logic        if_adel_out,
  output logic        inst_sram_en,
  output logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_rdata
);

  // The PC register sits one word before RESET_PC so that the normal
  // sequential increment produces RESET_PC as the first fetch address.
  localparam logic [31:0] PC_INIT = RESET_PC - 32'd4;

  logic [31:0] pc_r;
  logic        valid_r;
  logic [31:0] inst_buf;
  logic        buf_valid;

  logic        if_allowin;
  logic        handoff;
  logic        redirect;
  logic [31:0] next_pc;

  assign if_allowin = !valid_r || id_allowin_in;
  assign handoff    = valid_r && id_allowin_in;

  // The branch leaves decode on the same edge its delay slot leaves IF, so
  // the target is the very next fetch: no bubble, no squash.
  assign redirect = handoff && id_brcal_res_in;
  assign next_pc  = redirect ? id_bjpc_res_in : pc_r + 32'd4;

  // A misaligned address is still loaded into IF (to raise ADEL) but never
  // presented to the SRAM as a read.
  assign inst_sram_en   = if_allowin && !rst && (next_pc[1:0] == 2'b00);
  assign inst_sram_addr = next_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r      <= PC_INIT;
      valid_r   <= 1'b0;
      inst_buf  <= 32'd0;
      buf_valid <= 1'b0;
    end else begin
      if (if_allowin) begin
        pc_r    <= next_pc;
        valid_r <= 1'b1;
      end
      // SRAM data is only valid the cycle after a read, so on the first
      // stalled edge it is saved and then served from the buffer until the
      // instruction finally moves to decode.
      if (handoff) begin
        buf_valid <= 1'b0;
      end else if (valid_r && !buf_valid) begin
        inst_buf  <= inst_sram_rdata;
        buf_valid <= 1'b1;
      end
    end
  end

  assign if_valid_out    = valid_r;
  assign if_PC_out       = pc_r;
  assign if_NPC_out      = pc_r + 32'd4;
  assign if_NNPC_out     = pc_r + 32'd8;
  assign if_adel_out     = valid_r && (pc_r[1:0] != 2'b00);
  assign if_Instruct_out = if_adel_out ? 32'd0 :
                           (buf_valid ? inst_buf : inst_sram_rdata);

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage
//
// Directed bench for if_stage. A behavioural SRAM returns addr ^ 32'h1234_0000
// the cycle after a read and random garbage otherwise. Each fetch the bench
// expects is pushed into a scoreboard queue; the head of the queue is what IF
// should be holding, and it is popped when decode accepts it.
// ---------------------------------------------------------------------------
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
  localparam logic [31:0] XOR_KEY  = 32'h1234_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } fetch_rec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_allowin_in = 1'b0;
  logic        id_brcal_res_in = 1'b0;
  logic [31:0] id_bjpc_res_in = 32'd0;
  logic        if_valid_out;
  logic [31:0] if_PC_out;
  logic [31:0] if_NPC_out;
  logic [31:0] if_NNPC_out;
  logic [31:0] if_Instruct_out;
  logic        if_adel_out;
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_rdata = 32'd0;

  int total = 0;
  int bad = 0;
  fetch_rec_t sb_q[$];

  if_stage #(.RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_allowin_in   (id_allowin_in),
    .id_brcal_res_in (id_brcal_res_in),
    .id_bjpc_res_in  (id_bjpc_res_in),
    .if_valid_out    (if_valid_out),
    .if_PC_out       (if_PC_out),
    .if_NPC_out      (if_NPC_out),
    .if_NNPC_out     (if_NNPC_out),
    .if_Instruct_out (if_Instruct_out),
    .if_adel_out     (if_adel_out),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_rdata (inst_sram_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous SRAM: valid data only after a read cycle, garbage otherwise.
  always @(posedge clk) begin
    if (inst_sram_en)
      inst_sram_rdata <= inst_sram_addr ^ XOR_KEY;
    else
      inst_sram_rdata <= 32'hDEAD_0000 ^ $urandom();
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs after the falling edge, check just after, and
  // update the scoreboard for the edge that follows.
  task automatic applyStimulus(input logic allow, input logic br,
                               input logic [31:0] tgt,
                               input logic [31:0] exp_addr);
    fetch_rec_t rec;
    logic       fetch;
    @(negedge clk);
    rst             = 1'b0;
    id_allowin_in   = allow;
    id_brcal_res_in = br;
    id_bjpc_res_in  = tgt;
    #1;
    fetch = (sb_q.size() == 0) || allow;
    checkOutput("valid", 32'(if_valid_out), 32'(sb_q.size() != 0));
    checkOutput("addr", inst_sram_addr, exp_addr);
    checkOutput("en", 32'(inst_sram_en), 32'(fetch && (exp_addr[1:0] == 2'b00)));
    if (sb_q.size() != 0) begin
      rec = sb_q[0];
      checkOutput("pc", if_PC_out, rec.pc);
      checkOutput("npc", if_NPC_out, rec.pc + 32'd4);
      checkOutput("nnpc", if_NNPC_out, rec.pc + 32'd8);
      checkOutput("instr", if_Instruct_out, rec.instr);
      checkOutput("adel", 32'(if_adel_out), 32'(rec.adel));
      if (allow) void'(sb_q.pop_front());
    end
    if (fetch) begin
      rec.pc    = exp_addr;
      rec.adel  = (exp_addr[1:0] != 2'b00);
      rec.instr = rec.adel ? 32'd0 : (exp_addr ^ XOR_KEY);
      sb_q.push_back(rec);
    end
  endtask

  // Hold reset across one edge and check the reset values.
  task automatic applyReset(input logic allow);
    @(negedge clk);
    rst             = 1'b1;
    id_allowin_in   = allow;
    id_brcal_res_in = 1'b0;
    #1;
    checkOutput("rst_en_pre", 32'(inst_sram_en), 32'd0);
    @(negedge clk);
    #1;
    checkOutput("rst_valid", 32'(if_valid_out), 32'd0);
    checkOutput("rst_adel", 32'(if_adel_out), 32'd0);
    checkOutput("rst_en", 32'(inst_sram_en), 32'd0);
    checkOutput("rst_pc", if_PC_out, RESET_PC - 32'd4);
    checkOutput("rst_addr", inst_sram_addr, RESET_PC);
    sb_q.delete();
  endtask

  initial begin
    applyReset(1'b1);

    // Sequential fetch from reset with decode always accepting.
    applyStimulus(1'b1, 1'b0, 32'd0, 32'hBFC0_0000);
    applyStimulus(1'b1, 1'b0, 32'd0, 32'hBFC0_0004);
    applyStimulus(1'b1, 1'b0, 32'd0, 32'hBFC0_0008);
    applyStimulus(1'b1, 1'b0, 32'd0, 32'hBFC0_000C);
    applyStimulus(1'b1, 1'b0, 32'd0, 32'hBFC0_0010);

    // Decode stalls three cycles while IF holds BFC0_0010.
    applyStimulus(1'b0, 1'b0, 32'd0, 32'hBFC0_0014);
    applyStimulus(1'b0, 1'b0, 32'd0, 32'hBFC0_0014);
    applyStimulus(1'b0, 1'b0, 32'd0, 32'hBFC0_0014);
    applyStimulus(1'b1, 1'b0, 32'd0, 32'hBFC0_0014);
    applyStimulus(1'b1, 1'b0, 32'd0, 32'hBFC0_0018);
    applyStimulus(1'b1, 1'b0, 32'd0, 32'hBFC0_001C);
    applyStimulus(1'b1, 1'b0, 32'd0, 32'hBFC0_0020);

    // Taken branch with the delay slot BFC0_0020 in IF.
    applyStimulus(1'b1, 1'b1, 32'hBFC0_0100, 32'hBFC0_0100);
    applyStimulus(1'b1, 1'b0, 32'd0, 32'hBFC0_0104);

    // Branch taken while decode stalls: redirect only on the allowin cycle.
    applyStimulus(1'b0, 1'b1, 32'hBFC0_0200, 32'hBFC0_0108);
    applyStimulus(1'b0, 1'b1, 32'hBFC0_0200, 32'hBFC0_0108);
    applyStimulus(1'b1, 1'b1, 32'hBFC0_0200, 32'hBFC0_0200);

    // Misaligned target, then a misaligned sequential fetch.
    applyStimulus(1'b1, 1'b1, 32'hBFC0_0102, 32'hBFC0_0102);
    applyStimulus(1'b1, 1'b0, 32'd0, 32'hBFC0_0106);
    applyStimulus(1'b1, 1'b1, 32'hBFC0_0300, 32'hBFC0_0300);

    // Stall long enough to fill the buffer, then reset in the middle of it.
    applyStimulus(1'b0, 1'b0, 32'd0, 32'hBFC0_0304);
    applyStimulus(1'b0, 1'b0, 32'd0, 32'hBFC0_0304);
    applyReset(1'b0);
    applyStimulus(1'b1, 1'b0, 32'd0, 32'hBFC0_0000);
    applyStimulus(1'b1, 1'b0, 32'd0, 32'hBFC0_0004);

    // Address wrap-around at the top of the address space.
    applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    applyStimulus(1'b1, 1'b0, 32'd0, 32'h0000_0000);
    applyStimulus(1'b1, 1'b0, 32'd0, 32'h0000_0004);
    applyStimulus(1'b1, 1'b0, 32'd0, 32'h0000_0008);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
